lcd_bus_reader: RTL and testbench

Read-side controller for the character-LCD parallel bus (HD44780-style), the counterpart to the write/strobe path that drives the panel. On request it runs an LCD read cycle with RW=1: setup, an E high pulse, sample of DB, then hold. It returns the byte with a one-cycle valid strobe. It can optionally poll the busy flag until the panel is ready, so the command sequencer no longer needs fixed worst-case delays.

---
 rtl/lcd_pkg.sv | 27 ++
 rtl/lcd_phase_timer.sv | 24 ++
 rtl/lcd_bus_reader.sv | 163 ++++++++++++++++
 tb/tb_lcd_bus_reader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD bus (read and write paths).
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    EHIGH = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } lcd_state_e;

  localparam logic LCD_RS_CMD  = 1'b0;
  localparam logic LCD_RS_DATA = 1'b1;

  // Default bus timing in clock cycles, shared with the write path
  localparam int LCD_T_AS     = 2;
  localparam int LCD_T_PW     = 12;
  localparam int LCD_T_H      = 2;
  localparam int LCD_POLL_MAX = 1024;

  function automatic int lcd_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter for bus phase durations. Load N-1 on phase entry;
// done is high while the count reads zero (the phase's last cycle).
module lcd_phase_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Count down to zero and park there until reloaded
  always_ff @(posedge clock or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// Read-side controller for the HD44780-style parallel bus: setup, E pulse,
// sample, hold; optional busy-flag polling on the command register.
// Build option: LCD_NIBBLE_MODE_EN selects the 4-bit bus (two passes/byte).
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int T_AS     = LCD_T_AS,
  parameter int T_PW     = LCD_T_PW,
  parameter int T_H      = LCD_T_H,
  parameter int POLL_MAX = LCD_POLL_MAX
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       req,
  input  logic       req_rs,
  input  logic       poll,
  output logic       ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       timeout,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  input  logic [7:0] lcd_db_in,
  output logic       lcd_db_oe
);

  localparam int TW = $clog2(lcd_max3(T_AS, T_PW, T_H) + 1);
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [TW-1:0] LD_AS   = TW'(T_AS - 1);
  localparam logic [TW-1:0] LD_PW   = TW'(T_PW - 1);
  localparam logic [TW-1:0] LD_H    = TW'(T_H - 1);
  localparam logic [PW-1:0] PMAX_M1 = PW'(POLL_MAX - 1);

  lcd_state_e    state, nxt;
  logic          tload, tdone;
  logic [TW-1:0] tval;
  logic          accept, cap, retry, fin, to_nxt;
  logic          rs_q, poll_q, to_q;
  logic [PW-1:0] pcnt_q;
  logic [7:0]    rd_reg, rd_data_q;
`ifdef LCD_NIBBLE_MODE_EN
  logic          pass_q, pass_adv;
  logic [3:0]    unused_db_lo;
  assign unused_db_lo = lcd_db_in[3:0];
`endif

  lcd_phase_timer #(.W(TW)) u_tmr (
    .clock    (clock),
    .rst      (rst),
    .load     (tload),
    .load_val (tval),
    .done     (tdone)
  );

  // State register; async reset drops lcd_e immediately via the decode below
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next state, timer reload and per-phase strobes
  always_comb begin
    nxt    = state;
    tload  = 1'b0;
    tval   = LD_AS;
    accept = 1'b0;
    cap    = 1'b0;
    retry  = 1'b0;
    fin    = 1'b0;
    to_nxt = 1'b0;
`ifdef LCD_NIBBLE_MODE_EN
    pass_adv = 1'b0;
`endif
    case (state)
      IDLE: if (req) begin
        accept = 1'b1;
        nxt    = SETUP;
        tload  = 1'b1;
        tval   = LD_AS;
      end
      SETUP: if (tdone) begin
        nxt   = EHIGH;
        tload = 1'b1;
        tval  = LD_PW;
      end
      EHIGH: if (tdone) begin
        cap   = 1'b1;
        nxt   = HOLD;
        tload = 1'b1;
        tval  = LD_H;
      end
      HOLD: if (tdone) begin
`ifdef LCD_NIBBLE_MODE_EN
        if (!pass_q) begin
          pass_adv = 1'b1;
          nxt      = SETUP;
          tload    = 1'b1;
          tval     = LD_AS;
        end else
`endif
        if (poll_q && rd_reg[7] && (pcnt_q < PMAX_M1)) begin
          retry = 1'b1;
          nxt   = SETUP;
          tload = 1'b1;
          tval  = LD_AS;
        end else begin
          fin    = 1'b1;
          to_nxt = poll_q && rd_reg[7];
          nxt    = DONE;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Request latches, poll counter, capture and result registers
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rs_q      <= LCD_RS_CMD;
      poll_q    <= 1'b0;
      pcnt_q    <= '0;
      rd_reg    <= 8'h00;
      rd_data_q <= 8'h00;
      to_q      <= 1'b0;
`ifdef LCD_NIBBLE_MODE_EN
      pass_q    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        rs_q   <= req_rs;
        poll_q <= poll && (req_rs == LCD_RS_CMD);
        pcnt_q <= '0;
      end
      if (retry) pcnt_q <= pcnt_q + 1'b1;
`ifdef LCD_NIBBLE_MODE_EN
      if (accept || retry) pass_q <= 1'b0;
      else if (pass_adv)   pass_q <= 1'b1;
      if (cap) begin
        if (!pass_q) rd_reg[7:4] <= lcd_db_in[7:4];
        else         rd_reg[3:0] <= lcd_db_in[7:4];
      end
`else
      if (cap) rd_reg <= lcd_db_in;
`endif
      if (fin) begin
        rd_data_q <= rd_reg;
        to_q      <= to_nxt;
      end
    end
  end

  assign ready     = (state == IDLE);
  assign rd_valid  = (state == DONE);
  assign timeout   = (state == DONE) && to_q;
  assign rd_data   = rd_data_q;
  assign lcd_rs    = rs_q;
  assign lcd_rw    = (state != IDLE);
  assign lcd_e     = (state == EHIGH);
  assign lcd_db_oe = 1'b0;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Scoreboard bench for lcd_bus_reader: a bus responder feeds DB per E pulse,
// expected bytes/timeout/arrival cycle are queued at request time.
module tb_lcd_bus_reader;

  localparam int T_PW = 12;
  localparam int TRD  = 16;   // T_AS+T_PW+T_H with defaults
`ifdef LCD_NIBBLE_MODE_EN
  localparam int P = 2;
`else
  localparam int P = 1;
`endif

  typedef struct {
    logic [7:0] data;
    logic       to;
    int         cyc;
  } exp_t;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0, req_rs = 1'b0, poll = 1'b0;
  logic       ready, rd_valid, timeout;
  logic [7:0] rd_data;
  logic       lcd_rs, lcd_rw, lcd_e, lcd_db_oe;
  logic [7:0] lcd_db_in = 8'h00;

  exp_t       exp_q[$];
  logic [7:0] db_q[$];
  int         total = 0, bad = 0;
  int         cyc = 0, pulses = 0, nvalid = 0, e_len = 0;
  logic       prev_e = 1'b0;

  lcd_bus_reader #(.POLL_MAX(4)) dut (
    .clock     (clock),
    .rst       (rst),
    .req       (req),
    .req_rs    (req_rs),
    .poll      (poll),
    .ready     (ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .timeout   (timeout),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_db_in (lcd_db_in),
    .lcd_db_oe (lcd_db_oe)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One panel byte as seen on the bus for one logical read attempt
  task automatic push_byte(input logic [7:0] b);
`ifdef LCD_NIBBLE_MODE_EN
    db_q.push_back({b[7:4], 4'h5});
    db_q.push_back({b[3:0], 4'hA});
`else
    db_q.push_back(b);
`endif
  endtask

  // Panel model: present the next bus value as E rises
  always @(posedge lcd_e) begin
    if (db_q.size() > 0) lcd_db_in = db_q.pop_front();
    else                 lcd_db_in = 8'h00;
  end

  // Monitor: E width/phase checks and scoreboard compare on rd_valid
  always @(negedge clock) begin
    if (rst) begin
      e_len  = 0;
      prev_e = 1'b0;
    end else begin
      if (lcd_e) begin
        e_len++;
        chk("rw_in_e", lcd_rw, 1);
      end else if (prev_e) begin
        chk("e_width", e_len, T_PW);
        pulses++;
        e_len = 0;
      end
      prev_e = lcd_e;
      chk("db_oe", lcd_db_oe, 0);
      if (timeout && !rd_valid) chk("timeout_alone", 1, 0);
      if (rd_valid) begin
        nvalid++;
        if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rd_data", rd_data, e.data);
          chk("timeout", timeout, e.to);
          chk("latency", cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_ready();
    int w;
    w = 0;
    @(negedge clock);
    while (!ready && w < 100) begin
      @(negedge clock);
      w++;
    end
    if (!ready) chk("ready_wait", 0, 1);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() > 0 && w < 5000) begin
      @(negedge clock);
      w++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
    @(negedge clock);
  endtask

  // One request of n read attempts; caller has already queued bus bytes
  task automatic do_read(input logic rs, input logic pl, input int n,
                         input logic [7:0] data, input logic to);
    int   p0;
    exp_t e;
    wait_ready();
    p0 = pulses;
    req = 1'b1; req_rs = rs; poll = pl;
    e.data = data; e.to = to; e.cyc = cyc + 1 + n * P * TRD;
    exp_q.push_back(e);
    @(posedge clock); #1;
    req = 1'b0; poll = 1'b0;
    chk("rs_c1", lcd_rs, rs);
    chk("rw_c1", lcd_rw, 1);
    chk("e_c1", lcd_e, 0);
    chk("ready_c1", ready, 0);
    drain();
    chk("pulses", pulses - p0, n * P);
  endtask

  initial begin
    int   acc, per, p0, v0;
    exp_t e;
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc, per, p0, v0;
    exp_t e;
    repeat (3) @(negedge clock);
    chk("rst_ready", ready, 1);
    chk("rst_valid", rd_valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_data", rd_data, 8'h00);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_e", lcd_e, 0);
    rst = 1'b0;

    // Plain data-register read
    push_byte(8'hA5);
    do_read(1'b1, 1'b0, 1, 8'hA5, 1'b0);
    chk("idle_rw", lcd_rw, 0);
    chk("idle_rs_held", lcd_rs, 1);

    // Busy three times, then ready on the fourth read (just under the limit)
    push_byte(8'h80); push_byte(8'h80); push_byte(8'h80); push_byte(8'h25);
    do_read(1'b0, 1'b1, 4, 8'h25, 1'b0);

    // Always busy: limit of 4 reads reached
    for (int i = 0; i < 4; i++) push_byte(8'hFF);
    do_read(1'b0, 1'b1, 4, 8'hFF, 1'b1);

    // Poll ignored for the data register
    push_byte(8'h80);
    do_read(1'b1, 1'b1, 1, 8'h80, 1'b0);

    // Busy flag set but no polling: single read, no timeout
    push_byte(8'hC3);
    do_read(1'b0, 1'b0, 1, 8'hC3, 1'b0);

    // req held high: one accept per IDLE, fixed spacing
    per = P * TRD + 2;
    wait_ready();
    p0 = pulses; v0 = nvalid;
    acc = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      push_byte(8'hA1 + 8'(i));
      e.data = 8'hA1 + 8'(i); e.to = 1'b0; e.cyc = acc + P * TRD + i * per;
      exp_q.push_back(e);
    end
    req = 1'b1; req_rs = 1'b1;
    repeat (2 * per + 1) @(posedge clock);
    #1 req = 1'b0;
    chk("held_busy", ready, 0);
    drain();
    repeat (per) @(negedge clock);
    chk("held_pulses", pulses - p0, 3 * P);
    chk("held_valids", nvalid - v0, 3);

    // Reset in the middle of the E pulse
    wait_ready();
    push_byte(8'h5A);
    req = 1'b1; req_rs = 1'b0;
    @(posedge clock); #1 req = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("pre_rst_e", lcd_e, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_e", lcd_e, 0);
    chk("arst_rw", lcd_rw, 0);
    chk("arst_rs", lcd_rs, 0);
    chk("arst_ready", ready, 1);
    chk("arst_valid", rd_valid, 0);
    chk("arst_data", rd_data, 8'h00);
    db_q.delete();
    v0 = nvalid;
    repeat (2) @(posedge clock);
    @(negedge clock) rst = 1'b0;
    repeat (40) @(negedge clock);
    chk("no_valid_after_rst", nvalid - v0, 0);

    // Recovery read
    push_byte(8'h3C);
    do_read(1'b0, 1'b0, 1, 8'h3C, 1'b0);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
